// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/data requesters, the shared memory and the
// arbiter; the arbiter takes the slave view, the environment the master view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports,
// with data priority bounded by a starvation counter for fetch.
module mem_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t        r_state, w_state_nxt;
    owner_t        r_owner, w_owner_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [SW-1:0] r_starve, w_starve_nxt;
    logic          r_we, w_we_nxt;
    logic [31:0]   r_addr, w_addr_nxt;
    logic [31:0]   r_wdata, w_wdata_nxt;
    logic          r_if_ack, w_if_ack_nxt;
    logic          r_dm_ack, w_dm_ack_nxt;
    logic [31:0]   r_if_rdata, w_if_rdata_nxt;
    logic [31:0]   r_dm_rdata, w_dm_rdata_nxt;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_starve_full;
    logic w_grant_d;
    logic w_grant_i;

    // A port being acked this cycle is dropping its request, so skip it.
    assign w_if_elig     = bus.if_req & ~r_if_ack;
    assign w_dm_elig     = bus.dm_req & ~r_dm_ack;
    assign w_starve_full = (r_starve == SW'(STARVE_LIM));
    assign w_grant_d     = w_dm_elig & ~(w_if_elig & w_starve_full);
    assign w_grant_i     = w_if_elig & ~w_grant_d;

    // Next-state and datapath decisions for the IDLE/BUSY controller.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_cnt_nxt      = r_cnt;
        w_starve_nxt   = r_starve;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_if_ack_nxt   = 1'b0;
        w_dm_ack_nxt   = 1'b0;
        w_if_rdata_nxt = r_if_rdata;
        w_dm_rdata_nxt = r_dm_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = OWN_D;
                    w_cnt_nxt   = CNT_INIT;
                    w_addr_nxt  = bus.dm_addr;
                    w_wdata_nxt = bus.dm_wdata;
                    w_we_nxt    = bus.dm_wr;
                    if (bus.if_req && !w_starve_full) begin
                        w_starve_nxt = r_starve + SW'(1);
                    end
                end else if (w_grant_i) begin
                    w_state_nxt  = BUSY;
                    w_owner_nxt  = OWN_I;
                    w_cnt_nxt    = CNT_INIT;
                    w_addr_nxt   = bus.if_addr;
                    w_wdata_nxt  = '0;
                    w_we_nxt     = 1'b0;
                    w_starve_nxt = '0;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWN_D) begin
                        w_dm_ack_nxt = 1'b1;
                        if (!r_we) begin
                            w_dm_rdata_nxt = bus.mem_rdata;
                        end
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_I;
            r_cnt      <= '0;
            r_starve   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            r_starve   <= w_starve_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_if_ack   <= w_if_ack_nxt;
            r_dm_ack   <= w_dm_ack_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_dm_rdata <= w_dm_rdata_nxt;
        end
    end

    // Memory side is live only while BUSY; address/data hold when idle.
    assign bus.mem_en    = (r_state == BUSY);
    assign bus.mem_we    = (r_state == BUSY) & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for basic accesses plus
// hand-written reset, starvation and request-drop sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    assign ifb.if_req    = ifa.if_req;
    assign ifb.if_addr   = ifa.if_addr;
    assign ifb.dm_req    = ifa.dm_req;
    assign ifb.dm_wr     = ifa.dm_wr;
    assign ifb.dm_addr   = ifa.dm_addr;
    assign ifb.dm_wdata  = ifa.dm_wdata;
    assign ifb.mem_rdata = ifa.mem_rdata;

    mem_arbiter #(.LAT(2), .STARVE_LIM(4)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    mem_arbiter #(.LAT(1), .STARVE_LIM(4)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic [133:0] exp;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t row(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwr,
        input logic [31:0] daddr, input logic [31:0] dwd,
        input logic [31:0] mrd,
        input logic en, input logic we,
        input logic [31:0] maddr, input logic [31:0] mwd,
        input logic iack, input logic dack,
        input logic sif, input logic smem,
        input logic [31:0] ird, input logic [31:0] drd);
        vec_t v;
        v.ireq  = ireq;
        v.iaddr = iaddr;
        v.dreq  = dreq;
        v.dwr   = dwr;
        v.daddr = daddr;
        v.dwd   = dwd;
        v.mrd   = mrd;
        v.exp   = {en, we, maddr, mwd, iack, dack, sif, smem, ird, drd};
        return v;
    endfunction

    function automatic logic [133:0] act_a();
        return {ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata,
                ifa.if_ack, ifa.dm_ack, ifa.stall_if, ifa.stall_mem,
                ifa.if_rdata, ifa.dm_rdata};
    endfunction

    task automatic chk_vec(input string nm, input logic [133:0] act,
                           input logic [133:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifa.if_req    = 1'b0;
        ifa.if_addr   = '0;
        ifa.dm_req    = 1'b0;
        ifa.dm_wr     = 1'b0;
        ifa.dm_addr   = '0;
        ifa.dm_wdata  = '0;
        ifa.mem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic drop_test(input bit sel, input string nm);
        int   grants;
        int   acks;
        bit   prev_en;
        bit   drop;
        logic en;
        logic ack;
        logic [31:0] rd;
        grants  = 0;
        acks    = 0;
        prev_en = 1'b0;
        drop    = 1'b0;
        rd      = '0;
        do_reset();
        ifa.if_req    = 1'b1;
        ifa.if_addr   = 32'h44;
        ifa.mem_rdata = 32'h0000_0077;
        for (int c = 0; c < 12; c++) begin
            if (drop) ifa.if_req = 1'b0;
            @(negedge clk);
            en  = sel ? ifb.mem_en : ifa.mem_en;
            ack = sel ? ifb.if_ack : ifa.if_ack;
            if (en && !prev_en) grants++;
            prev_en = en;
            if (ack) begin
                acks++;
                drop = 1'b1;
                rd   = sel ? ifb.if_rdata : ifa.if_rdata;
            end
            next_cycle();
        end
        chk_int({nm, "_grants"}, grants, 1);
        chk_int({nm, "_acks"}, acks, 1);
        chk_int({nm, "_rdata"}, int'(rd), 32'h77);
    endtask

    initial begin
        int    nack;
        int    cyc;
        int    bad;
        bit    both;
        string seq;

        vecs[0]  = row(1, 32'h10, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = row(1, 32'h10, 0, 0, 0, 0, 0,
                       1, 0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
        vecs[2]  = row(1, 32'h10, 0, 0, 0, 0, 32'h2402_0005,
                       1, 0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
        vecs[3]  = row(1, 32'h10, 0, 0, 0, 0, 0,
                       0, 0, 32'h10, 0, 1, 0, 0, 0, 32'h2402_0005, 0);
        vecs[4]  = row(0, 0, 0, 0, 0, 0, 0,
                       0, 0, 32'h10, 0, 0, 0, 0, 0, 32'h2402_0005, 0);
        vecs[5]  = row(1, 32'h20, 1, 0, 32'h100, 0, 0,
                       0, 0, 32'h10, 0, 0, 0, 1, 1, 32'h2402_0005, 0);
        vecs[6]  = row(1, 32'h20, 1, 0, 32'h100, 0, 0,
                       1, 0, 32'h100, 0, 0, 0, 1, 1, 32'h2402_0005, 0);
        vecs[7]  = row(1, 32'h20, 1, 0, 32'h100, 0, 32'h1111_2222,
                       1, 0, 32'h100, 0, 0, 0, 1, 1, 32'h2402_0005, 0);
        vecs[8]  = row(1, 32'h20, 1, 0, 32'h100, 0, 0,
                       0, 0, 32'h100, 0, 0, 1, 1, 0, 32'h2402_0005, 32'h1111_2222);
        vecs[9]  = row(1, 32'h20, 0, 0, 0, 0, 0,
                       1, 0, 32'h20, 0, 0, 0, 1, 0, 32'h2402_0005, 32'h1111_2222);
        vecs[10] = row(1, 32'h20, 0, 0, 0, 0, 32'h3333_4444,
                       1, 0, 32'h20, 0, 0, 0, 1, 0, 32'h2402_0005, 32'h1111_2222);
        vecs[11] = row(1, 32'h20, 0, 0, 0, 0, 0,
                       0, 0, 32'h20, 0, 1, 0, 0, 0, 32'h3333_4444, 32'h1111_2222);
        vecs[12] = row(0, 0, 0, 0, 0, 0, 0,
                       0, 0, 32'h20, 0, 0, 0, 0, 0, 32'h3333_4444, 32'h1111_2222);
        vecs[13] = row(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0,
                       0, 0, 32'h20, 0, 0, 0, 0, 1, 32'h3333_4444, 32'h1111_2222);
        vecs[14] = row(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0,
                       1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 1,
                       32'h3333_4444, 32'h1111_2222);
        vecs[15] = row(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 32'h5555_5555,
                       1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 1,
                       32'h3333_4444, 32'h1111_2222);
        vecs[16] = row(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0,
                       0, 0, 32'h40, 32'hDEAD_BEEF, 0, 1, 0, 0,
                       32'h3333_4444, 32'h1111_2222);
        vecs[17] = row(0, 0, 0, 0, 0, 0, 0,
                       0, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0,
                       32'h3333_4444, 32'h1111_2222);

        rst = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_vec("reset_state", act_a(), '0);
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ifa.if_req    = vecs[i].ireq;
            ifa.if_addr   = vecs[i].iaddr;
            ifa.dm_req    = vecs[i].dreq;
            ifa.dm_wr     = vecs[i].dwr;
            ifa.dm_addr   = vecs[i].daddr;
            ifa.dm_wdata  = vecs[i].dwd;
            ifa.mem_rdata = vecs[i].mrd;
            @(negedge clk);
            chk_vec($sformatf("vec%0d", i), act_a(), vecs[i].exp);
            next_cycle();
        end

        ifa.dm_req  = 1'b1;
        ifa.dm_addr = 32'h80;
        next_cycle();
        @(negedge clk);
        chk_int("abort_busy_en", int'(ifa.mem_en), 1);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk_vec("abort_outputs", act_a(), '0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clk);
            if (ifa.dm_ack || ifa.if_ack || ifa.mem_en) bad++;
        end
        chk_int("abort_no_ack", bad, 0);

        do_reset();
        ifa.if_addr = 32'h200;
        ifa.dm_addr = 32'h300;
        nack = 0;
        cyc  = 0;
        both = 1'b0;
        seq  = "";
        while (nack < 10 && cyc < 400) begin
            ifa.dm_req = 1'b1;
            ifa.if_req = ~ifa.dm_ack;
            @(negedge clk);
            if (ifa.dm_ack && ifa.if_ack) both = 1'b1;
            if (ifa.dm_ack) begin
                seq = {seq, "D"};
                nack++;
            end
            if (ifa.if_ack) begin
                seq = {seq, "I"};
                nack++;
            end
            cyc++;
            next_cycle();
        end
        chk_int("starve_ack_count", nack, 10);
        chk_str("starve_order", seq, "DDDDIDDDDI");
        chk_int("one_ack_per_cycle", int'(both), 0);

        drop_test(1'b0, "drop_lat2");
        drop_test(1'b1, "drop_lat1");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
